// File: rtl/cordic_af_scheduler.sv
// cordic_af_scheduler: round-robin arbiter/sequencer sharing one multi-cycle
// CORDIC activation unit among NUM_REQ requesters. One operation in flight;
// the unit is started with a one-cycle pulse, watched by a watchdog timer, and
// the tagged result (or a timeout abort) is returned on one response channel.
module cordic_af_scheduler #(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_x,
  input  logic [NUM_REQ-1:0]   req_sel,
  output logic                 af_start,
  output logic [N-1:0]         af_x,
  output logic                 af_sel,
  input  logic                 af_done,
  input  logic [N-1:0]         af_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [N-1:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [7:0]           timeout_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   r_id;
  logic [N-1:0]      r_x;
  logic              r_sel;
  logic [N-1:0]      r_data;
  logic              r_err;
  logic [TW-1:0]     r_timer;
  logic [7:0]        r_tocnt;

  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic              w_timeout;
  logic [NUM_REQ-1:0] w_onehot;

  // Round-robin pick: first valid requester after the last granted one, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_last) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = ID_W'((int'(r_last) + k) % NUM_REQ);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_timeout = (r_timer == TIMER_LAST);

  // Next-state logic of the sequencing FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_ISSUE;
        else         w_state_nxt = S_IDLE;
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // done wins over a coincident watchdog expiry
        if (af_done)        w_state_nxt = S_RESP;
        else if (w_timeout) w_state_nxt = S_RESP;
        else                w_state_nxt = S_WAIT;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture, watchdog timer, result capture and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= ID_W'(NUM_REQ - 1);
      r_id    <= '0;
      r_x     <= '0;
      r_sel   <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
      r_tocnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_x   <= req_x[w_win*N +: N];
            r_sel <= req_sel[w_win];
            r_id  <= w_win;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          if (af_done) begin
            r_data <= af_result;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_data <= '0;
            r_err  <= 1'b1;
            if (r_tocnt != 8'hFF) r_tocnt <= r_tocnt + 8'd1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) r_last <= r_id;
        end
        default: r_timer <= '0;
      endcase
    end
  end

  assign w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

  // Grant is combinational in IDLE and forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) req_ready = w_onehot;
    else                                         req_ready = '0;
  end

  assign af_start    = (r_state == S_ISSUE);
  assign af_x        = r_x;
  assign af_sel      = r_sel;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_id      = r_id;
  assign rsp_data    = r_data;
  assign rsp_err     = r_err;
  assign busy        = (r_state != S_IDLE);
  assign timeout_cnt = r_tocnt;

endmodule

// File: tb/tb_cordic_af_scheduler.sv
// Self-checking bench for cordic_af_scheduler. The bench plays the requesters,
// the activation unit and the response sink; expectations come from a
// transaction-level model (round-robin pick, latency rules, timeout counting).
module tb_cordic_af_scheduler;
  localparam int N = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W = 2;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_x = '0;
  logic [NUM_REQ-1:0]   req_sel = '0;
  logic                 af_start;
  logic [N-1:0]         af_x;
  logic                 af_sel;
  logic                 af_done = 1'b0;
  logic [N-1:0]         af_result = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [ID_W-1:0]      rsp_id;
  logic [N-1:0]         rsp_data;
  logic                 rsp_err;
  logic                 busy;
  logic [7:0]           timeout_cnt;

  int n_vec = 0;
  int n_err = 0;
  int last_g = NUM_REQ - 1;
  int exp_to = 0;

  cordic_af_scheduler #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_sel(req_sel), .af_start(af_start), .af_x(af_x),
    .af_sel(af_sel), .af_done(af_done), .af_result(af_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first set bit after last_g, wrapping; -1 when none.
  function automatic int model_winner(input logic [NUM_REQ-1:0] mask);
    int w = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (w < 0 && mask[(last_g + k) % NUM_REQ]) w = (last_g + k) % NUM_REQ;
    end
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_val({tag, "_af_start"}, 32'(af_start), 32'd0);
    check_val({tag, "_af_x"}, 32'(af_x), 32'd0);
    check_val({tag, "_af_sel"}, 32'(af_sel), 32'd0);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check_val({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check_val({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'd0);
  endtask

  // One IDLE cycle with nobody requesting; optional stale af_done pulse.
  task automatic idle_cycle(input bit done_pulse);
    req_valid = '0;
    af_done = done_pulse;
    af_result = 8'($urandom);
    #1;
    check_val("idle_ready", 32'(req_ready), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("idle_tocnt", 32'(timeout_cnt), 32'(exp_to));
    step();
    af_done = 1'b0;
  endtask

  // Full transaction: grant, start, wait d cycles for done (d > TIMEOUT means
  // never), then hold the response for 'hold' cycles before accepting it.
  task automatic run_op(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*N-1:0] xs,
                        input logic [NUM_REQ-1:0] sels, input int d, input int hold,
                        input logic [N-1:0] res);
    int w;
    logic [N-1:0] ex;
    logic es;
    logic [N-1:0] exp_d;
    logic exp_e;
    req_valid = mask; req_x = xs; req_sel = sels; af_done = 1'b0; rsp_ready = 1'b0;
    #1;
    w = model_winner(mask);
    check_val("arb_busy", 32'(busy), 32'd0);
    check_val("arb_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    ex = xs[w*N +: N];
    es = sels[w];
    step();
    // ISSUE: a done pulse here must be ignored
    req_valid = 4'($urandom); req_x = $urandom; af_done = 1'b1; af_result = ~res;
    #1;
    check_val("iss_start", 32'(af_start), 32'd1);
    check_val("iss_x", 32'(af_x), 32'(ex));
    check_val("iss_sel", 32'(af_sel), 32'(es));
    check_val("iss_ready", 32'(req_ready), 32'd0);
    check_val("iss_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    af_done = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      af_done = (i == d);
      af_result = (i == d) ? res : 8'($urandom);
      #1;
      check_val("wait_start", 32'(af_start), 32'd0);
      check_val("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("wait_busy", 32'(busy), 32'd1);
      check_val("wait_ready", 32'(req_ready), 32'd0);
      check_val("wait_x", 32'(af_x), 32'(ex));
      check_val("wait_sel", 32'(af_sel), 32'(es));
      step();
      af_done = 1'b0;
      if (i == d) break;
    end
    if (d <= TIMEOUT) begin
      exp_d = res; exp_e = 1'b0;
    end else begin
      exp_d = '0; exp_e = 1'b1;
      if (exp_to < 255) exp_to++;
    end
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      af_done = 1'($urandom); af_result = 8'($urandom); req_valid = 4'($urandom);
      #1;
      check_val("rsp_valid", 32'(rsp_valid), 32'd1);
      check_val("rsp_id", 32'(rsp_id), 32'(w));
      check_val("rsp_data", 32'(rsp_data), 32'(exp_d));
      check_val("rsp_err", 32'(rsp_err), 32'(exp_e));
      check_val("rsp_tocnt", 32'(timeout_cnt), 32'(exp_to));
      check_val("rsp_ready_out", 32'(req_ready), 32'd0);
      check_val("rsp_start", 32'(af_start), 32'd0);
      step();
    end
    rsp_ready = 1'b0; af_done = 1'b0; req_valid = '0;
    last_g = w;
  endtask

  initial begin
    logic [NUM_REQ-1:0] m;
    #3;
    check_all_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // single request from requester 0, done in 3rd WAIT cycle
    run_op(4'b0001, 32'h0000_0010, 4'b0001, 3, 0, 8'h0C);
    idle_cycle(1'b0);

    // all four contend, done after one WAIT cycle: strict rotation
    for (int k = 0; k < 5; k++) run_op(4'b1111, 32'h0403_0201, 4'b0101, 1, 0, 8'(8'hA0 + k));

    // watchdog expiry, then a late done is ignored
    run_op(4'b0010, 32'h1122_3344, 4'b0000, TIMEOUT + 1, 0, 8'h55);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // response back-pressure for 5 cycles with requesters 1 and 2 pending
    run_op(4'b0110, 32'hDEAD_BEEF, 4'b1010, 2, 5, 8'h77);
    run_op(4'b0110, 32'hCAFE_F00D, 4'b0110, 2, 0, 8'h66);

    // done on the last legal WAIT cycle beats the watchdog
    run_op(4'b1000, 32'h8000_0000, 4'b1000, TIMEOUT, 1, 8'h3C);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
      m = 4'($urandom);
      if (m == 4'd0) m = 4'd1 << $urandom_range(0, 3);
      run_op(m, $urandom, 4'($urandom), $urandom_range(1, TIMEOUT + 3),
             $urandom_range(0, 3), 8'($urandom));
    end

    // asynchronous reset in the middle of WAIT with requester 2 in flight
    req_valid = 4'b0100; req_x = 32'h0099_0000; req_sel = 4'b0100;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    step(); step();
    check_all_zero("inreset");
    rst_n = 1'b1;
    last_g = NUM_REQ - 1;
    exp_to = 0;
    req_valid = '0;
    idle_cycle(1'b0);
    run_op(4'b0101, 32'h0011_0022, 4'b0001, 2, 0, 8'h42);

    // saturate the timeout counter
    for (int t = 0; t < 257; t++) run_op(4'b0001, 32'h0, 4'b0, TIMEOUT + 1, 0, 8'h00);
    idle_cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
